// File: rtl/cpu_control_unit_pkg.sv
// Shared opcodes, ALU codes, FSM state encoding and instruction-field helpers
// for the 8-bit CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;

  // Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, FETCH_IMM, EXECUTE, WRITEBACK, HALT
  } state_e;

  function automatic logic [3:0] instr_opcode(input logic [7:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [7:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [7:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch port: req/addr from the sequencer, ready/rdata
// back from memory.
interface cpu_control_unit_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready;
  logic [7:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/cpu_instr_decode.sv
// Combinational opcode decoder: ALU operation plus instruction-class flags.
module cpu_instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       is_ldi,
  output logic       is_halt,
  output logic       is_nop,
  output logic       is_illegal,
  output logic       writes_rd
);

  always_comb begin
    alu_op     = ALU_ADD;
    is_ldi     = 1'b0;
    is_halt    = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    writes_rd  = 1'b0;
    case (opcode)
      OP_NOP:  is_nop = 1'b1;
      OP_ADD:  begin alu_op = ALU_ADD;    writes_rd = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB;    writes_rd = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND;    writes_rd = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;     writes_rd = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR;    writes_rd = 1'b1; end
      OP_MOV:  begin alu_op = ALU_PASS_B; writes_rd = 1'b1; end
      // Result comes through the immediate path; ALU op is don't-care
      OP_LDI:  begin alu_op = ALU_PASS_B; writes_rd = 1'b1; is_ldi = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode sequencer for the 8-bit CPU datapath.
// Define CTRL_PERF_EN to add the retired-instruction counter port.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PERF_CNT_W = 16,
  parameter bit AUTOSTART  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            pc_in,
  cpu_control_unit_if.master    imem,
  output logic [1:0]            rf_read_addr1,
  output logic [1:0]            rf_read_addr2,
  output logic                  rf_write_enable,
  output logic [1:0]            rf_write_addr,
  output logic                  pc_write_enable,
  output logic [2:0]            alu_op,
  output logic                  wb_sel,
  output logic [7:0]            imm_data,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op
`ifdef CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] retired_count
`endif
);

  if (PERF_CNT_W < 1) begin : g_bad_cfg
    $error("PERF_CNT_W must be at least 1");
  end

  state_e     state, state_nxt;
  logic [7:0] ir;
  logic [2:0] dec_alu_op;
  logic       is_ldi, is_halt, is_nop, is_illegal, writes_rd;
  logic       accept;

  cpu_instr_decode u_dec (
    .opcode     (instr_opcode(ir)),
    .alu_op     (dec_alu_op),
    .is_ldi     (is_ldi),
    .is_halt    (is_halt),
    .is_nop     (is_nop),
    .is_illegal (is_illegal),
    .writes_rd  (writes_rd)
  );

  // Request is a pure state decode so an async reset drops it at once
  assign imem.imem_req  = (state == FETCH) || (state == FETCH_IMM);
  assign imem.imem_addr = imem.imem_req ? pc_in : 8'h00;
  assign accept         = imem.imem_req && imem.imem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start || AUTOSTART) state_nxt = FETCH;
      FETCH:     if (imem.imem_ready) state_nxt = DECODE;
      DECODE: begin
        if (is_ldi)                    state_nxt = FETCH_IMM;
        else if (is_halt)              state_nxt = HALT;
        else if (is_nop || is_illegal) state_nxt = FETCH;
        else                           state_nxt = EXECUTE;
      end
      FETCH_IMM: if (imem.imem_ready) state_nxt = WRITEBACK;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = FETCH;
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= 8'h00;
      imm_data <= 8'h00;
    end else begin
      if (state == FETCH && imem.imem_ready)     ir       <= imem.imem_rdata;
      if (state == FETCH_IMM && imem.imem_ready) imm_data <= imem.imem_rdata;
    end
  end

  assign pc_write_enable = accept;
  assign rf_write_enable = (state == WRITEBACK) && writes_rd;
  assign rf_write_addr   = (state == WRITEBACK) ? instr_rd(ir) : 2'd0;
  assign wb_sel          = (state == WRITEBACK) && is_ldi;
  assign alu_op          = (state == EXECUTE || state == WRITEBACK) ? dec_alu_op : ALU_ADD;
  assign rf_read_addr1   = (state == IDLE) ? 2'd0 : instr_rd(ir);
  assign rf_read_addr2   = (state == IDLE) ? 2'd0 : instr_rs(ir);
  assign busy            = (state != IDLE) && (state != HALT);
  assign halted          = (state == HALT);
  assign illegal_op      = (state == DECODE) && is_illegal;

`ifdef CTRL_PERF_EN
  // Single-byte no-write instructions retire in DECODE, everything else in WRITEBACK
  logic retire;
  assign retire = (state == WRITEBACK) ||
                  ((state == DECODE) && (is_nop || is_illegal || is_halt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    retired_count <= '0;
    else if (retire) retired_count <= retired_count + PERF_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit with a wait-state
// instruction memory and a PC register model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [7:0] pc;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic       rf_write_enable, pc_write_enable, wb_sel, busy, halted, illegal_op;
  logic [2:0] alu_op;
  logic [7:0] imm_data;
`ifdef CTRL_PERF_EN
  logic [15:0] retired_count;
`endif

  logic [7:0] mem [256];
  int wait_cycles;
  int wcnt;
  int pass_cnt, total;

  always #5 clk = ~clk;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .pc_in           (pc),
    .imem            (bus),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .pc_write_enable (pc_write_enable),
    .alu_op          (alu_op),
    .wb_sel          (wb_sel),
    .imm_data        (imm_data),
    .busy            (busy),
    .halted          (halted),
    .illegal_op      (illegal_op)
`ifdef CTRL_PERF_EN
    ,
    .retired_count   (retired_count)
`endif
  );

  // Memory with programmable wait states before ready
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ready)    wcnt <= wcnt + 1;
    else                                         wcnt <= 0;
  end
  assign bus.imem_ready = bus.imem_req && (wcnt >= wait_cycles);
  assign bus.imem_rdata = mem[bus.imem_addr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)             pc <= 8'h00;
    else if (pc_load)         pc <= pc_load_val;
    else if (pc_write_enable) pc <= pc + 8'h01;
  end

  typedef struct packed {
    logic [1:0] wa;
    logic       wb;
    logic [2:0] alu;
    logic [1:0] ra1;
    logic [1:0] ra2;
    logic [7:0] imm;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] alog[$];
  int n_req, n_pcwe, n_rfwe, n_ill, n_overlap;

  always @(negedge clk) begin
    if (bus.imem_req)  n_req <= n_req + 1;
    if (pc_write_enable) begin
      n_pcwe <= n_pcwe + 1;
      alog.push_back(bus.imem_addr);
    end
    if (rf_write_enable) begin
      n_rfwe <= n_rfwe + 1;
      wlog.push_back('{rf_write_addr, wb_sel, alu_op, rf_read_addr1, rf_read_addr2, imm_data});
    end
    if (illegal_op) n_ill <= n_ill + 1;
    if (rf_write_enable && pc_write_enable) n_overlap <= n_overlap + 1;
  end

  function automatic logic [31:0] outs();
    return {bus.imem_req, bus.imem_addr, pc_write_enable, rf_write_enable, rf_write_addr,
            rf_read_addr1, rf_read_addr2, alu_op, wb_sel, imm_data, busy, halted, illegal_op};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; wait_cycles = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // c0 = cycles already elapsed since the start edge; exp = cycle halted is seen
  task automatic wait_halt(input string nm, input int c0, input int exp);
    int cyc;
    cyc = c0;
    while (!halted && cyc < 300) begin
      tick(1);
      cyc++;
    end
    total++; if (halted !== 1'b1) $display("FAIL %s_halt_timeout: halted=%b after %0d cycles", nm, halted, cyc); else pass_cnt++;
    total++; if (cyc !== exp) $display("FAIL %s_latency: got %0d cycles expected %0d", nm, cyc, exp); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; wait_cycles = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    tick(1);
    total++; if (outs() !== 32'h0) $display("FAIL reset_held: outputs got %h expected 0", outs()); else pass_cnt++;
    reset_n = 1'b1;
    tick(2);
    total++; if (outs() !== 32'h0) $display("FAIL reset_idle: outputs got %h expected 0", outs()); else pass_cnt++;
`ifdef CTRL_PERF_EN
    total++; if (retired_count !== 16'h0) $display("FAIL reset_perf: got %0d expected 0", retired_count); else pass_cnt++;
`endif
  endtask

  task automatic test_alu_single();
    int r0, p0, w0;
    do_reset();
    mem[0] = 8'h16; mem[1] = 8'hF0;
    r0 = n_req; p0 = n_pcwe; w0 = wlog.size();
    pulse_start();
    total++; if ({bus.imem_req, bus.imem_addr, pc_write_enable, busy} !== {1'b1, 8'h00, 1'b1, 1'b1})
      $display("FAIL add_fetch: got %b expected 1_00000000_1_1", {bus.imem_req, bus.imem_addr, pc_write_enable, busy}); else pass_cnt++;
    tick(1);
    total++; if ({bus.imem_req, pc_write_enable, rf_write_enable, alu_op, illegal_op} !== 7'b0)
      $display("FAIL add_decode: got %b expected 0", {bus.imem_req, pc_write_enable, rf_write_enable, alu_op, illegal_op}); else pass_cnt++;
    tick(1);
    total++; if ({rf_write_enable, alu_op, rf_read_addr1, rf_read_addr2} !== {1'b0, 3'd0, 2'd1, 2'd2})
      $display("FAIL add_execute: got %b expected 0_000_01_10", {rf_write_enable, alu_op, rf_read_addr1, rf_read_addr2}); else pass_cnt++;
    tick(1);
    total++; if ({rf_write_enable, rf_write_addr, wb_sel, alu_op, pc_write_enable} !== {1'b1, 2'd1, 1'b0, 3'd0, 1'b0})
      $display("FAIL add_writeback: got %b expected 1_01_0_000_0", {rf_write_enable, rf_write_addr, wb_sel, alu_op, pc_write_enable}); else pass_cnt++;
    tick(1);
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h01})
      $display("FAIL add_next_fetch: got %b_%h expected 1_01", bus.imem_req, bus.imem_addr); else pass_cnt++;
    wait_halt("add", 5, 7);
    total++; if ((n_req - r0) !== 2 || (n_pcwe - p0) !== 2 || (wlog.size() - w0) !== 1)
      $display("FAIL add_counts: req %0d pcwe %0d writes %0d expected 2 2 1", n_req - r0, n_pcwe - p0, wlog.size() - w0); else pass_cnt++;
  endtask

  task automatic test_ldi();
    int p0, w0;
    do_reset();
    mem[0] = 8'h7C; mem[1] = 8'hA5; mem[2] = 8'hF0;
    p0 = n_pcwe; w0 = wlog.size();
    pulse_start();
    tick(2);
    total++; if ({bus.imem_req, bus.imem_addr, pc_write_enable} !== {1'b1, 8'h01, 1'b1})
      $display("FAIL ldi_fetch_imm: got %b_%h_%b expected 1_01_1", bus.imem_req, bus.imem_addr, pc_write_enable); else pass_cnt++;
    tick(1);
    total++; if ({rf_write_enable, rf_write_addr, wb_sel, imm_data, pc_write_enable} !== {1'b1, 2'd3, 1'b1, 8'hA5, 1'b0})
      $display("FAIL ldi_writeback: got %b_%0d_%b_%h_%b expected 1_3_1_a5_0", rf_write_enable, rf_write_addr, wb_sel, imm_data, pc_write_enable); else pass_cnt++;
    wait_halt("ldi", 4, 7);
    total++; if ((n_pcwe - p0) !== 3 || (wlog.size() - w0) !== 1)
      $display("FAIL ldi_counts: pcwe %0d writes %0d expected 3 1", n_pcwe - p0, wlog.size() - w0); else pass_cnt++;
    total++; if (imm_data !== 8'hA5) $display("FAIL ldi_imm_hold: got %h expected a5", imm_data); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    logic [3:0] req_seq, pcwe_seq;
    logic       addr_ok;
    do_reset();
    wait_cycles = 3;
    mem[0] = 8'h16; mem[1] = 8'hF0;
    addr_ok = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      req_seq[i]  = bus.imem_req;
      pcwe_seq[i] = pc_write_enable;
      if (bus.imem_addr !== 8'h00) addr_ok = 1'b0;
      tick(1);
    end
    total++; if (req_seq !== 4'b1111) $display("FAIL wait_req_held: got %b expected 1111", req_seq); else pass_cnt++;
    total++; if (pcwe_seq !== 4'b1000) $display("FAIL wait_pcwe: got %b expected 1000", pcwe_seq); else pass_cnt++;
    total++; if ({addr_ok, bus.imem_req} !== 2'b10) $display("FAIL wait_addr_release: got %b expected 10", {addr_ok, bus.imem_req}); else pass_cnt++;
    wait_halt("wait", 5, 13);
  endtask

  task automatic test_illegal();
    int i0, w0;
    do_reset();
    mem[0] = 8'h95; mem[1] = 8'h16; mem[2] = 8'hF0;
    i0 = n_ill; w0 = wlog.size();
    pulse_start();
    tick(1);
    total++; if (illegal_op !== 1'b1) $display("FAIL ill_pulse: got %b expected 1", illegal_op); else pass_cnt++;
    tick(1);
    total++; if ({illegal_op, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h01})
      $display("FAIL ill_next_fetch: got %b_%b_%h expected 0_1_01", illegal_op, bus.imem_req, bus.imem_addr); else pass_cnt++;
    wait_halt("ill", 3, 9);
    total++; if ((n_ill - i0) !== 1 || (wlog.size() - w0) !== 1 || wlog[w0].wa !== 2'd1)
      $display("FAIL ill_counts: pulses %0d writes %0d expected 1 1 (addr 1)", n_ill - i0, wlog.size() - w0); else pass_cnt++;
`ifdef CTRL_PERF_EN
    total++; if (retired_count !== 16'd3) $display("FAIL ill_perf: got %0d expected 3", retired_count); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    int  w0;
    wr_t exp [3];
    exp[0] = '{2'd2, 1'b0, 3'd1, 2'd2, 2'd3, 8'h00};
    exp[1] = '{2'd0, 1'b0, 3'd5, 2'd0, 2'd1, 8'h00};
    exp[2] = '{2'd3, 1'b0, 3'd4, 2'd3, 2'd2, 8'h00};
    do_reset();
    mem[0] = 8'h2B; mem[1] = 8'h61; mem[2] = 8'h5E; mem[3] = 8'h00; mem[4] = 8'hF0;
    w0 = wlog.size();
    pulse_start();
    wait_halt("b2b", 1, 17);
    total++; if ((wlog.size() - w0) !== 3) $display("FAIL b2b_writes: got %0d expected 3", wlog.size() - w0); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (w0 + i < wlog.size()) begin
        total++; if (wlog[w0+i] !== exp[i]) $display("FAIL b2b_wr%0d: got %h expected %h", i, wlog[w0+i], exp[i]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_pc_wrap();
    int a0;
    do_reset();
    mem[8'hFF] = 8'h78; mem[0] = 8'h99; mem[1] = 8'hF0;
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick(1);
    pc_load = 1'b0;
    a0 = alog.size();
    pulse_start();
    wait_halt("wrap", 1, 7);
    total++; if (alog.size() - a0 !== 3 || {alog[a0], alog[a0+1], alog[a0+2]} !== 24'hFF0001)
      $display("FAIL wrap_addrs: got %0d fetches expected ff,00,01", alog.size() - a0); else pass_cnt++;
    total++; if ({wlog[$].wa, wlog[$].wb, wlog[$].imm} !== {2'd2, 1'b1, 8'h99})
      $display("FAIL wrap_write: got %h expected 2_1_99", {wlog[$].wa, wlog[$].wb, wlog[$].imm}); else pass_cnt++;
  endtask

  task automatic test_halt();
    int r0;
    do_reset();
    mem[0] = 8'h7D; mem[1] = 8'h3C; mem[2] = 8'hF0;
    pulse_start();
    wait_halt("halt", 1, 7);
    total++; if ({halted, busy, imm_data} !== {1'b1, 1'b0, 8'h3C})
      $display("FAIL halt_state: got %b_%b_%h expected 1_0_3c", halted, busy, imm_data); else pass_cnt++;
    r0 = n_req;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; tick(1); start = 1'b0; tick(1);
    end
    total++; if ((n_req - r0) !== 0 || halted !== 1'b1)
      $display("FAIL halt_absorb: req cycles %0d halted %b expected 0 1", n_req - r0, halted); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total++; if (outs() !== 32'h0) $display("FAIL halt_reset: outputs got %h expected 0", outs()); else pass_cnt++;
    tick(1);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid_ldi();
    int f0, guard;
    do_reset();
    wait_cycles = 2;
    mem[0] = 8'h7C; mem[1] = 8'h55;
    f0 = n_rfwe;
    pulse_start();
    guard = 0;
    while (!(bus.imem_req && pc == 8'h01) && guard < 30) begin
      tick(1);
      guard++;
    end
    total++; if (guard >= 30) $display("FAIL midldi_reach: FETCH_IMM not seen within %0d cycles", guard); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total++; if ({bus.imem_req, imm_data} !== 9'h0) $display("FAIL midldi_req_drop: got %b_%h expected 0_00", bus.imem_req, imm_data); else pass_cnt++;
    tick(2);
    wait_cycles = 0;
    mem[0] = 8'h16; mem[1] = 8'hF0;
    reset_n = 1'b1;
    tick(1);
    total++; if ((n_rfwe - f0) !== 0) $display("FAIL midldi_no_write: got %0d writes expected 0", n_rfwe - f0); else pass_cnt++;
    pulse_start();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00})
      $display("FAIL midldi_restart: got %b_%h expected 1_00", bus.imem_req, bus.imem_addr); else pass_cnt++;
    wait_halt("restart", 1, 7);
    total++; if ((n_rfwe - f0) !== 1 || wlog[$].wa !== 2'd1)
      $display("FAIL restart_write: got %0d writes expected 1 to addr 1", n_rfwe - f0); else pass_cnt++;
`ifdef CTRL_PERF_EN
    total++; if (retired_count !== 16'd2) $display("FAIL restart_perf: got %0d expected 2", retired_count); else pass_cnt++;
`endif
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_alu_single();
    test_ldi();
    test_wait_states();
    test_illegal();
    test_back_to_back();
    test_pc_wrap();
    test_halt();
    test_reset_mid_ldi();
    total++; if (n_overlap !== 0) $display("FAIL we_overlap: got %0d overlapping cycles expected 0", n_overlap); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
